dbus_demux: RTL and testbench
=============================

# dbus_demux

Data-bus demultiplexer between the zeroriscy core data port and its two slaves: the data `sp_ram` and a memory-mapped peripheral port. It decodes each core request by address, forwards it to the selected slave, and records the target in an in-order ID FIFO. It then steers that slave's response back to the core. Unmapped addresses are answered by an internal error responder with `data_err_o`.

## Interface

Reset is decided as: **one clock; reset is asynchronous and active-high.**

Parameters:
- `MEM_BASE`, default `32'h0000_0000`: memory region base.
- `MEM_MASK`, default `32'hFFFF_0000`: memory region hits when `(addr & MEM_MASK) == MEM_BASE`.
- `PER_BASE`, default `32'h1000_0000`: peripheral region base.
- `PER_MASK`, default `32'hFFFF_F000`: peripheral region mask.
- `MAX_OUTSTANDING`, default `2`: ID FIFO depth, ≥1.

Ports (`CW = $clog2(MAX_OUTSTANDING+1)`):
- `clk_i` in 1: clock.
- `rst_i` in 1: async active-high reset.
- Core side:
  - `data_req_i` in 1, `data_gnt_o` out 1, `data_rvalid_o` out 1.
  - `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32.
  - `data_rdata_o` out 32, `data_err_o` out 1.
- Memory side:
  - `mem_req_o` out 1, `mem_gnt_i` in 1, `mem_rvalid_i` in 1.
  - `mem_we_o` out 1, `mem_be_o` out 4, `mem_addr_o` out 32, `mem_wdata_o` out 32, `mem_rdata_i` in 32.
- Peripheral side: `per_*` with the same set, directions and widths as `mem_*`.
- Status:
  - `outstanding_o` out CW: FIFO occupancy.
  - `proto_err_o` out 1: sticky flag for a response protocol violation.

## Operation

- **Decode** (combinational): target = MEM if the memory match is true, else PER if the peripheral match is true, else ERR. MEM wins if both regions match.
- **Pass-through:** `we/be/addr/wdata` drive both slave ports unconditionally. Only `req` is gated.
- **Request gating:** `mem_req_o = data_req_i & tgt==MEM & !full`; `per_req_o` likewise for PER.
- **Grant:** `data_gnt_o` = the selected slave's `gnt_i` & `!full`; for ERR it is `!full`.
- **Full:** full when `outstanding == MAX_OUTSTANDING`. A pop in the same cycle does not free a slot that cycle, so there is no rvalid→gnt combinational path.
- **Push:** on `data_req_i & data_gnt_o`, the target ID is pushed into the FIFO.
- **Response source:** the FIFO head selects the response source.
  - Head MEM/PER: `data_rvalid_o` = that slave's `rvalid_i`, with `data_rdata_o` = its `rdata_i` and `data_err_o = 0`.
  - Head ERR: the internal responder asserts `data_rvalid_o = 1` in the first cycle the entry is at head, with `data_rdata_o = 0` and `data_err_o = 1`.
- **Pop:** the FIFO pops on `data_rvalid_o`. Push and pop in the same cycle leave occupancy unchanged.
- **Protocol errors:** `proto_err_o` sets and stays set until reset on either of:
  - `rvalid_i` from a slave that is not at the head;
  - any `rvalid_i` while the FIFO is empty.
  
  The offending response is dropped and nothing pops.
- **Idle outputs:** when `data_rvalid_o = 0`, `data_rdata_o = 0` and `data_err_o = 0`.

## Timing

- **Reset values:** FIFO empty, `outstanding_o = 0`, `proto_err_o = 0`, all `req_o`/`gnt_o`/`rvalid_o` = 0, `data_rdata_o = 0`, `data_err_o = 0`.
- **Request path:** zero added latency (combinational from core to slave).
- **Response path:** zero added latency for MEM/PER (combinational mux on `rvalid_i`/`rdata_i`).
- **ERR latency:** the earliest `data_rvalid_o` is the cycle after grant. If older entries are ahead, it follows in order after them.
- **Handshake:** the core holds `req` and its attributes until `gnt`. Ungranted requests leave no state.
- **Throughput:** back-to-back grants are allowed every cycle while not full. With `MAX_OUTSTANDING = 1` and 1-cycle slaves, the sustained rate is one transfer per 2 cycles.
- **Reset mid-transaction:** the FIFO clears immediately and asynchronously. Slave responses arriving after reset deasserts with an empty FIFO set `proto_err_o`; the SoC resets the slaves together with this block.

## Structure

- Package `dbus_pkg` contains:
  - `typedef enum logic [1:0] {TGT_MEM, TGT_PER, TGT_ERR} dbus_tgt_e`
  - the default base/mask localparams.
- Sub-module `dbus_id_fifo`: parameterised depth, element `dbus_tgt_e`, push/pop/full/empty/count, async active-high reset.
- Top level holds the decoder, gating, error responder and protocol checker.

## Test plan

- **Memory store then load:** store to `0x0000_0010` then load it, with the mem model granting immediately and `rvalid` 1 cycle after grant.
  - The load returns the written data with `data_err_o = 0`.
  - `outstanding_o` sequence is 0,1,1,0.
- **Unmapped load:** load from `0x2000_0000`.
  - `gnt` in the request cycle, `rvalid` the next cycle, with `rdata = 0` and `err = 1`.
  - `mem_req_o` and `per_req_o` never assert.
- **Ordering across targets:** MEM load then PER load back-to-back; the peripheral is ready early but the memory `rvalid` is delayed 3 cycles.
  - With the peripheral holding its response until the MEM response: responses arrive in order and `proto_err_o` stays 0.
  - With the peripheral asserting early (out of order): `proto_err_o` = 1 and the early response is dropped.
- **Full:** `MAX_OUTSTANDING = 2`, three consecutive requests with no responses.
  - The third `gnt` stays 0 until the cycle after the first `rvalid`.
- **Async reset:** assert `rst_i` mid-cycle with 2 outstanding.
  - `outstanding_o = 0` and all `req`/`gnt`/`rvalid` low without waiting for a clock edge.
  - Normal transfers resume after release.

Source files
------------

// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_pkg
// Purpose  : Shared types and default address map for the data-bus demux.
//            dbus_tgt_e identifies which responder owns a transaction.
// Revision : 1.0 - initial release
// ============================================================================
package dbus_pkg;

    typedef enum logic [1:0] {
        TGT_MEM = 2'd0,
        TGT_PER = 2'd1,
        TGT_ERR = 2'd2
    } dbus_tgt_e;

    localparam logic [31:0] c_DEF_MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] c_DEF_MEM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] c_DEF_PER_BASE = 32'h1000_0000;
    localparam logic [31:0] c_DEF_PER_MASK = 32'hFFFF_F000;

endpackage
`default_nettype wire

// File: rtl/dbus_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dbus_id_fifo
// Purpose  : In-order FIFO of response-source IDs for outstanding requests.
// Ports    : clk, rst (async active-high)
//            i_push/i_tgt - enqueue a target ID
//            i_pop        - dequeue the head
//            o_head       - ID at the head (valid when !o_empty)
//            o_full/o_empty/o_count - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module dbus_id_fifo
    import dbus_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  dbus_tgt_e     i_tgt,
    input  logic          i_pop,
    output dbus_tgt_e     o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    dbus_tgt_e     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dbus_demux.sv
`default_nettype none
// ============================================================================
// Module   : dbus_demux
// Purpose  : Splits the core data port between sp_ram (MEM) and a peripheral
//            port (PER) by address; unmapped addresses get an internal error
//            response. Responses are returned in request order.
// Ports    : clk_i, rst_i (async active-high)
//            data_*  - core data port (req/gnt/rvalid protocol)
//            mem_*   - memory slave port
//            per_*   - peripheral slave port
//            outstanding_o - number of requests awaiting response
//            proto_err_o   - sticky: slave responded out of turn
// Revision : 1.0 - initial release
// ============================================================================
module dbus_demux
    import dbus_pkg::*;
#(
    parameter logic [31:0] MEM_BASE        = c_DEF_MEM_BASE,
    parameter logic [31:0] MEM_MASK        = c_DEF_MEM_MASK,
    parameter logic [31:0] PER_BASE        = c_DEF_PER_BASE,
    parameter logic [31:0] PER_MASK        = c_DEF_PER_MASK,
    parameter int          MAX_OUTSTANDING = 2,
    localparam int         CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    // core side
    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,
    // memory side
    output logic          mem_req_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    // peripheral side
    output logic          per_req_o,
    input  logic          per_gnt_i,
    input  logic          per_rvalid_i,
    output logic          per_we_o,
    output logic [3:0]    per_be_o,
    output logic [31:0]   per_addr_o,
    output logic [31:0]   per_wdata_o,
    input  logic [31:0]   per_rdata_i,
    // status
    output logic [CW-1:0] outstanding_o,
    output logic          proto_err_o
);

    dbus_tgt_e w_tgt;
    dbus_tgt_e w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_gnt;
    logic      w_push;
    logic      w_rvalid;
    logic      w_viol;
    logic      r_proto_err;

    // Address decode; MEM takes priority on overlap.
    always_comb begin
        if ((data_addr_i & MEM_MASK) == MEM_BASE) begin
            w_tgt = TGT_MEM;
        end else if ((data_addr_i & PER_MASK) == PER_BASE) begin
            w_tgt = TGT_PER;
        end else begin
            w_tgt = TGT_ERR;
        end
    end

    // Request and grant are held low while reset is asserted so the
    // slaves and core see an idle bus immediately, not at the next edge.
    always_comb begin
        case (w_tgt)
            TGT_MEM: w_gnt = mem_gnt_i;
            TGT_PER: w_gnt = per_gnt_i;
            default: w_gnt = 1'b1;
        endcase
        w_gnt = w_gnt & data_req_i & !w_full & !rst_i;
    end

    assign mem_req_o  = data_req_i & (w_tgt == TGT_MEM) & !w_full & !rst_i;
    assign per_req_o  = data_req_i & (w_tgt == TGT_PER) & !w_full & !rst_i;
    assign data_gnt_o = w_gnt;
    assign w_push     = w_gnt;

    assign mem_we_o    = data_we_i;
    assign mem_be_o    = data_be_i;
    assign mem_addr_o  = data_addr_i;
    assign mem_wdata_o = data_wdata_i;
    assign per_we_o    = data_we_i;
    assign per_be_o    = data_be_i;
    assign per_addr_o  = data_addr_i;
    assign per_wdata_o = data_wdata_i;

    dbus_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_tgt   (w_tgt),
        .i_pop   (w_rvalid),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_o)
    );

    // Response steering. An ERR entry answers in its first cycle at head,
    // so no extra state is needed for the error responder.
    always_comb begin
        w_rvalid     = 1'b0;
        data_rdata_o = '0;
        data_err_o   = 1'b0;
        if (!w_empty) begin
            case (w_head)
                TGT_MEM: begin
                    w_rvalid     = mem_rvalid_i;
                    data_rdata_o = mem_rvalid_i ? mem_rdata_i : '0;
                end
                TGT_PER: begin
                    w_rvalid     = per_rvalid_i;
                    data_rdata_o = per_rvalid_i ? per_rdata_i : '0;
                end
                default: begin
                    w_rvalid   = 1'b1;
                    data_err_o = 1'b1;
                end
            endcase
        end
    end

    assign data_rvalid_o = w_rvalid;

    // A slave answering when it does not own the head is dropped and flagged.
    assign w_viol = (mem_rvalid_i && (w_empty || (w_head != TGT_MEM))) ||
                    (per_rvalid_i && (w_empty || (w_head != TGT_PER)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_proto_err <= 1'b0;
        end else if (w_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_dbus_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_demux
// Purpose  : Self-checking bench for dbus_demux (default parameters,
//            MAX_OUTSTANDING = 2). Combinational decode vectors from a table,
//            then hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_demux;

    logic        clk;
    logic        rst;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        per_req_o, per_gnt_i, per_rvalid_i, per_we_o;
    logic [3:0]  per_be_o;
    logic [31:0] per_addr_o, per_wdata_o, per_rdata_i;
    logic [1:0]  outstanding_o;
    logic        proto_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    dbus_demux dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .per_req_o     (per_req_o),
        .per_gnt_i     (per_gnt_i),
        .per_rvalid_i  (per_rvalid_i),
        .per_we_o      (per_we_o),
        .per_be_o      (per_be_o),
        .per_addr_o    (per_addr_o),
        .per_wdata_o   (per_wdata_o),
        .per_rdata_i   (per_rdata_i),
        .outstanding_o (outstanding_o),
        .proto_err_o   (proto_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] addr;
        logic        req;
        logic        mg;
        logic        pg;
        logic        e_mreq;
        logic        e_preq;
        logic        e_gnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 4 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h1000_0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{32'h1000_0FFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h1000_1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h2000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h0001_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h1000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst          = 1'b1;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        per_gnt_i    = 1'b0;
        per_rvalid_i = 1'b0;
        per_rdata_i  = 32'h0;

        // ---------------- reset state (unmapped request held) ----------------
        #3;
        data_req_i  = 1'b1;
        data_addr_i = 32'h2000_0000;
        #1;
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_proto_err",   32'(proto_err_o),   32'd0);
        chk("rst_gnt",         32'(data_gnt_o),    32'd0);
        chk("rst_rvalid",      32'(data_rvalid_o), 32'd0);
        chk("rst_rdata",       data_rdata_o,       32'd0);
        chk("rst_err",         32'(data_err_o),    32'd0);
        chk("rst_mem_req",     32'(mem_req_o),     32'd0);
        chk("rst_per_req",     32'(per_req_o),     32'd0);
        data_req_i = 1'b0;
        tick();
        rst = 1'b0;

        // ---------------- table-driven decode / gating ----------------
        for (int i = 0; i < 10; i++) begin
            tick();
            data_addr_i  = vecs[i].addr;
            data_req_i   = vecs[i].req;
            mem_gnt_i    = vecs[i].mg;
            per_gnt_i    = vecs[i].pg;
            data_we_i    = i[0];
            data_be_i    = 4'(i + 1);
            data_wdata_i = vecs[i].addr ^ 32'hA5A5_A5A5;
            settle();
            chk($sformatf("vec%0d_mem_req", i), 32'(mem_req_o),  32'(vecs[i].e_mreq));
            chk($sformatf("vec%0d_per_req", i), 32'(per_req_o),  32'(vecs[i].e_preq));
            chk($sformatf("vec%0d_gnt", i),     32'(data_gnt_o), 32'(vecs[i].e_gnt));
            chk($sformatf("vec%0d_mem_addr", i), mem_addr_o,  vecs[i].addr);
            chk($sformatf("vec%0d_per_wdata", i), per_wdata_o, vecs[i].addr ^ 32'hA5A5_A5A5);
            chk($sformatf("vec%0d_be_we", i), {27'd0, per_be_o, mem_we_o}, {27'd0, 4'(i + 1), i[0]});
            // Withdraw before the edge so no entry is pushed.
            data_req_i = 1'b0;
        end
        tick();
        chk("vec_outstanding", 32'(outstanding_o), 32'd0);

        mem_gnt_i = 1'b1;
        per_gnt_i = 1'b1;
        data_be_i = 4'hF;

        // ---------------- memory store then load ----------------
        tick();
        data_req_i = 1'b1; data_we_i = 1'b1;
        data_addr_i = 32'h0000_0010; data_wdata_i = 32'hCAFE_BABE;
        settle();
        chk("st_gnt",  32'(data_gnt_o),    32'd1);
        chk("st_occ0", 32'(outstanding_o), 32'd0);
        tick();
        data_we_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
        settle();
        chk("st_rvalid", 32'(data_rvalid_o), 32'd1);
        chk("ld_gnt",    32'(data_gnt_o),    32'd1);
        chk("st_occ1",   32'(outstanding_o), 32'd1);
        tick();
        data_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_BABE;
        settle();
        chk("ld_rvalid", 32'(data_rvalid_o), 32'd1);
        chk("ld_rdata",  data_rdata_o,       32'hCAFE_BABE);
        chk("ld_err",    32'(data_err_o),    32'd0);
        chk("ld_occ2",   32'(outstanding_o), 32'd1);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        settle();
        chk("ld_occ3",       32'(outstanding_o), 32'd0);
        chk("ld_idle_rdata", data_rdata_o,       32'd0);

        // ---------------- unmapped load ----------------
        tick();
        data_req_i = 1'b1; data_addr_i = 32'h2000_0000;
        settle();
        chk("um_gnt",     32'(data_gnt_o),          32'd1);
        chk("um_reqs0",   32'({mem_req_o, per_req_o}), 32'd0);
        chk("um_rvalid0", 32'(data_rvalid_o),       32'd0);
        tick();
        data_req_i = 1'b0;
        settle();
        chk("um_rvalid1", 32'(data_rvalid_o),       32'd1);
        chk("um_rdata",   data_rdata_o,             32'd0);
        chk("um_err",     32'(data_err_o),          32'd1);
        chk("um_reqs1",   32'({mem_req_o, per_req_o}), 32'd0);
        tick();
        settle();
        chk("um_rvalid2", 32'(data_rvalid_o), 32'd0);
        chk("um_occ",     32'(outstanding_o), 32'd0);

        // ---------------- in-order MEM then PER ----------------
        tick();
        data_req_i = 1'b1; data_addr_i = 32'h0000_0020;
        settle();
        chk("io_gnt_mem", 32'(data_gnt_o), 32'd1);
        tick();
        data_addr_i = 32'h1000_0000;
        settle();
        chk("io_gnt_per", 32'(data_gnt_o), 32'd1);
        chk("io_per_req", 32'(per_req_o),  32'd1);
        tick();
        data_req_i = 1'b0;
        settle();
        chk("io_occ2", 32'(outstanding_o), 32'd2);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        settle();
        chk("io_mem_rvalid", 32'(data_rvalid_o), 32'd1);
        chk("io_mem_rdata",  data_rdata_o,       32'h1111_1111);
        tick();
        mem_rvalid_i = 1'b0;
        per_rvalid_i = 1'b1; per_rdata_i = 32'h2222_2222;
        settle();
        chk("io_per_rvalid", 32'(data_rvalid_o), 32'd1);
        chk("io_per_rdata",  data_rdata_o,       32'h2222_2222);
        tick();
        per_rvalid_i = 1'b0;
        settle();
        chk("io_occ0",  32'(outstanding_o), 32'd0);
        chk("io_proto", 32'(proto_err_o),   32'd0);

        // ---------------- out-of-order PER response ----------------
        tick();
        data_req_i = 1'b1; data_addr_i = 32'h0000_0020;
        tick();
        data_addr_i = 32'h1000_0000;
        tick();
        data_req_i = 1'b0;
        per_rvalid_i = 1'b1; per_rdata_i = 32'h0000_0BAD;
        settle();
        chk("oo_dropped", 32'(data_rvalid_o), 32'd0);
        chk("oo_occ2",    32'(outstanding_o), 32'd2);
        tick();
        per_rvalid_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        settle();
        chk("oo_proto",     32'(proto_err_o), 32'd1);
        chk("oo_mem_rdata", data_rdata_o,     32'h1111_1111);
        tick();
        mem_rvalid_i = 1'b0;
        per_rvalid_i = 1'b1; per_rdata_i = 32'h2222_2222;
        settle();
        chk("oo_per_rdata", data_rdata_o,       32'h2222_2222);
        chk("oo_occ1",      32'(outstanding_o), 32'd1);
        tick();
        per_rvalid_i = 1'b0;
        settle();
        chk("oo_occ0",        32'(outstanding_o), 32'd0);
        chk("oo_proto_stick", 32'(proto_err_o),   32'd1);

        // ---------------- full: third request held off ----------------
        tick();
        data_req_i = 1'b1; data_addr_i = 32'h0000_0040;
        settle();
        chk("fu_gnt1", 32'(data_gnt_o), 32'd1);
        tick();
        settle();
        chk("fu_gnt2", 32'(data_gnt_o), 32'd1);
        tick();
        settle();
        chk("fu_gnt3_blocked", 32'(data_gnt_o), 32'd0);
        chk("fu_mem_req",      32'(mem_req_o),  32'd0);
        chk("fu_occ",          32'(outstanding_o), 32'd2);
        tick();
        settle();
        chk("fu_gnt3_still", 32'(data_gnt_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_4444;
        settle();
        chk("fu_pop_rvalid",   32'(data_rvalid_o), 32'd1);
        chk("fu_gnt_pop_cyc",  32'(data_gnt_o),    32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("fu_occ_after", 32'(outstanding_o), 32'd1);
        chk("fu_gnt_after", 32'(data_gnt_o),    32'd1);
        tick();
        settle();
        chk("fu_occ_full", 32'(outstanding_o), 32'd2);

        // ---------------- async reset with 2 outstanding ----------------
        rst = 1'b1;
        #1;
        chk("ar_occ",    32'(outstanding_o), 32'd0);
        chk("ar_reqs",   32'({mem_req_o, per_req_o}), 32'd0);
        chk("ar_gnt",    32'(data_gnt_o),    32'd0);
        chk("ar_rvalid", 32'(data_rvalid_o), 32'd0);
        chk("ar_proto",  32'(proto_err_o),   32'd0);
        data_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        tick();
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0030;
        settle();
        chk("rs_gnt",     32'(data_gnt_o), 32'd1);
        chk("rs_mem_req", 32'(mem_req_o),  32'd1);
        tick();
        data_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0033;
        settle();
        chk("rs_rvalid", 32'(data_rvalid_o), 32'd1);
        chk("rs_rdata",  data_rdata_o,       32'h0000_0033);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("rs_occ",   32'(outstanding_o), 32'd0);
        chk("rs_proto", 32'(proto_err_o),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
